countertest: RTL and testbench
==============================

# countertest

Two-operand, two-digit decimal calculator with a multiplexed 4-digit seven-segment display driver. Four push-button inputs step BCD digits to build operands A and B, each in the range 00–99. A one-hot operation selector picks A+B, A−B, A×B or A÷B. The block drives the board's common-anode display directly and sits between the debounced board I/O and the display pins.

## Interface
- REFRESH_W, 18: width of the display refresh counter. Its top 2 bits select the active digit.
- clk  in  1  system clock; all state changes on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- original  in  1  1 = show the operands even when an operation is selected.
- in  in  4  digit-step buttons: in[0] = A tens, in[1] = A units, in[2] = B tens, in[3] = B units.
- operations  in  4  operation select: [0] add, [1] subtract, [2] multiply, [3] divide.
- y  out  7  segments {g,f,e,d,c,b,a}, active low.
- Anode_Activate  out  4  digit enables, active low; bit 3 = leftmost digit.

## Operation
- Each in[i] passes through a 2-FF synchronizer followed by rising-edge detection.
- Each detected edge increments the corresponding BCD digit: 0→1→…→9→0 (wrap). No carry into the adjacent digit.
- Operand values: A = 10·Atens + Aunits; B = 10·Btens + Bunits.
- Operation priority when several bits are set: lowest index wins.
- Result register (14-bit binary magnitude plus sign) is updated every cycle:
  - add: A+B, range 0–198.
  - subtract: A−B. A negative result is handled per the Configuration section.
  - multiply: A×B, range 0–9801.
  - divide: integer quotient floor(A/B). B=0 gives the error display "----".
- Result to display: binary magnitude is converted to 4 BCD digits combinationally (double-dabble). Leading zeros are shown.
- Display source:
  - operations == 0 or original == 1: digits {Atens, Aunits, Btens, Bunits}.
  - otherwise: the result digits.
- Segment encoding:
  - digits 0–9 use the standard patterns; 0 = 7'b1000000, 8 = 7'b0000000.
  - minus = 7'b0111111.
- Operand changes while an operation is selected update the result live.

## Timing
- Button press latency: a digit updates on the 3rd rising clk edge after in[i] is first sampled high. Input pulses must cover at least one rising edge.
- Result and display source: registered, 1-cycle latency after operations, original, or an operand change.
- Refresh counter: free-running REFRESH_W bits and wraps.
  - Digit index = counter[REFRESH_W-1:REFRESH_W-2].
  - Index 0 → Anode_Activate = 4'b1110 (rightmost digit); index 3 → 4'b0111.
  - y always matches the currently enabled digit; exactly one anode is low at any time.
- Reset, asynchronous (effective without a clock):
  - all digits, the result, the synchronizers and the refresh counter clear to 0.
  - Anode_Activate = 4'b1110 and y = 7'b1000000 while reset is held.
- A press coincident with reset release is ignored.

## Configuration
- SUB_SIGN_EN defined:
  - a negative difference displays '-' on digit 3 and the magnitude on digits 2..0.
  - Example: 32−98 shows "-066".
- SUB_SIGN_EN undefined: a negative difference saturates to 0000.

## Test plan
- Reset asserted → Anode_Activate = 1110, y = 1000000; after release, all four digits show 0.
- Press in[0..3] 9 times each → display "9999"; with operations = 0010 → "0000"; with 0001 → "0198"; with 1000 → "0001"; with 0100 → "9801".
- Press in[3] 9 more times (wraps 9→0→…→8) → B = 98; with operations = 0001 → "0197".
- Press in[0] 4 times and in[1] 3 times → A = 32; with 0100 → "3136"; with 1000 → "0000"; with 0010 → "-066" when SUB_SIGN_EN is defined, "0000" when it is not.
- Set original = 1 during multiply → display reverts to the operands "3298".
- Set B = 00 and select divide → "----"; set operations = 0011 → add takes priority.

Source files
------------

// File: rtl/countertest.sv
// countertest: two-operand, two-digit decimal calculator driving a
// multiplexed 4-digit common-anode seven-segment display.
//
// Operand digits are stepped by four synchronized, edge-detected buttons.
// The selected operation (lowest set bit of 'operations' wins) is evaluated
// every cycle into a registered result. The result is converted to BCD and
// shown by scanning one digit per refresh slot.
//
// Optional feature macro: SUB_SIGN_EN
//   defined   - a negative difference shows '-' on digit 3 and |A-B| below it
//   undefined - a negative difference saturates to 0000
//
// No state machine here: the only sequencing is the free-running refresh
// counter, whose top two bits are the active digit index.
module countertest #(
  parameter int REFRESH_W = 18
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       original,
  input  logic [3:0] in,
  input  logic [3:0] operations,
  output logic [6:0] y,
  output logic [3:0] Anode_Activate
);

  // Internal display codes: 0-9 are decimal digits, 10 is the minus bar
  // (also used for the "----" divide-by-zero display).
  localparam logic [3:0] CODE_MINUS = 4'd10;

  // Button synchronizer stages and edge-detect history.
  logic [3:0] sync1, sync2, sync3;
  logic [3:0] rise;

  // Operand BCD digits.
  logic [3:0] a_tens, a_units, b_tens, b_units;

  // Binary operand values (0..99).
  logic [6:0] op_a, op_b;

  // Next-state result and registered result.
  logic [13:0] nxt_mag;
  logic        nxt_neg;
  logic        nxt_err;
  logic [13:0] res_mag;
  logic        res_neg;
  logic        res_err;

  // Registered display source select and operand snapshot, so operand view
  // and result view share the same one-cycle latency.
  logic        show_ops;
  logic [3:0]  snap_at, snap_au, snap_bt, snap_bu;

  // BCD conversion of the result magnitude.
  logic [15:0] bcd;

  // Per-position display codes, position 3 = leftmost.
  logic [3:0] code3, code2, code1, code0;
  logic [3:0] cur_code;

  // Refresh counter and active digit index.
  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           digit_idx;

  // Wrapping BCD increment without carry-out.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    if (d >= 4'd9) bcd_inc = 4'd0;
    else           bcd_inc = d + 4'd1;
  endfunction

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 4'b0;
      sync2 <= 4'b0;
      sync3 <= 4'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // Each detected press steps its own digit; digits never carry into each other.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_tens  <= 4'd0;
      a_units <= 4'd0;
      b_tens  <= 4'd0;
      b_units <= 4'd0;
    end else begin
      if (rise[0]) a_tens  <= bcd_inc(a_tens);
      if (rise[1]) a_units <= bcd_inc(a_units);
      if (rise[2]) b_tens  <= bcd_inc(b_tens);
      if (rise[3]) b_units <= bcd_inc(b_units);
    end
  end

  assign op_a = 7'(a_tens) * 7'd10 + 7'(a_units);
  assign op_b = 7'(b_tens) * 7'd10 + 7'(b_units);

  // Arithmetic for the highest-priority (lowest-index) selected operation.
  always_comb begin
    nxt_mag = 14'd0;
    nxt_neg = 1'b0;
    nxt_err = 1'b0;
    if (operations[0]) begin
      nxt_mag = 14'(op_a) + 14'(op_b);
    end else if (operations[1]) begin
      if (op_a >= op_b) begin
        nxt_mag = 14'(op_a - op_b);
      end else begin
`ifdef SUB_SIGN_EN
        nxt_neg = 1'b1;
        nxt_mag = 14'(op_b - op_a);
`else
        nxt_mag = 14'd0;
`endif
      end
    end else if (operations[2]) begin
      nxt_mag = 14'(op_a) * 14'(op_b);
    end else if (operations[3]) begin
      if (op_b == 7'd0) nxt_err = 1'b1;
      else              nxt_mag = 14'(op_a / op_b);
    end
  end

  // Result, display source and operand snapshot refresh every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_mag  <= 14'd0;
      res_neg  <= 1'b0;
      res_err  <= 1'b0;
      show_ops <= 1'b1;
      snap_at  <= 4'd0;
      snap_au  <= 4'd0;
      snap_bt  <= 4'd0;
      snap_bu  <= 4'd0;
    end else begin
      res_mag  <= nxt_mag;
      res_neg  <= nxt_neg;
      res_err  <= nxt_err;
      show_ops <= (operations == 4'b0000) || original;
      snap_at  <= a_tens;
      snap_au  <= a_units;
      snap_bt  <= b_tens;
      snap_bu  <= b_units;
    end
  end

  // Double-dabble: shift-and-add-3 binary to 4-digit BCD.
  always_comb begin
    logic [29:0] sh;
    sh = {16'd0, res_mag};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14 + 4*d +: 4] >= 4'd5) sh[14 + 4*d +: 4] = sh[14 + 4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    bcd = sh[29:14];
  end

  // Choose what each display position shows.
  always_comb begin
    code3 = bcd[15:12];
    code2 = bcd[11:8];
    code1 = bcd[7:4];
    code0 = bcd[3:0];
    if (show_ops) begin
      code3 = snap_at;
      code2 = snap_au;
      code1 = snap_bt;
      code0 = snap_bu;
    end else if (res_err) begin
      code3 = CODE_MINUS;
      code2 = CODE_MINUS;
      code1 = CODE_MINUS;
      code0 = CODE_MINUS;
    end else if (res_neg) begin
      code3 = CODE_MINUS;
    end
  end

  // Free-running refresh counter; wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) refresh_cnt <= '0;
    else       refresh_cnt <= refresh_cnt + 1'b1;
  end

  assign digit_idx = refresh_cnt[REFRESH_W-1:REFRESH_W-2];

  // Enable one digit and pick its code; index 0 is the rightmost digit.
  always_comb begin
    Anode_Activate = 4'b1110;
    cur_code       = code0;
    case (digit_idx)
      2'd0: begin Anode_Activate = 4'b1110; cur_code = code0; end
      2'd1: begin Anode_Activate = 4'b1101; cur_code = code1; end
      2'd2: begin Anode_Activate = 4'b1011; cur_code = code2; end
      2'd3: begin Anode_Activate = 4'b0111; cur_code = code3; end
      default: begin Anode_Activate = 4'b1110; cur_code = code0; end
    endcase
  end

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  always_comb begin
    case (cur_code)
      4'd0:       y = 7'b1000000;
      4'd1:       y = 7'b1111001;
      4'd2:       y = 7'b0100100;
      4'd3:       y = 7'b0110000;
      4'd4:       y = 7'b0011001;
      4'd5:       y = 7'b0010010;
      4'd6:       y = 7'b0000010;
      4'd7:       y = 7'b1111000;
      4'd8:       y = 7'b0000000;
      4'd9:       y = 7'b0010000;
      CODE_MINUS: y = 7'b0111111;
      default:    y = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_countertest.sv
// tb_countertest: directed-vector bench for countertest. Uses a short
// refresh counter so one full display scan takes 16 cycles.
//
// Handshake note: buttons are level inputs held high for one clock; the
// display is sampled on falling edges, away from the active rising edge.
module tb_countertest;

  localparam int RW = 4;

  logic       clk;
  logic       rstn;
  logic       original;
  logic [3:0] in;
  logic [3:0] operations;
  logic [6:0] y;
  logic [3:0] Anode_Activate;

  int checks;
  int errors;

  countertest #(.REFRESH_W(RW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .original       (original),
    .in             (in),
    .operations     (operations),
    .y              (y),
    .Anode_Activate (Anode_Activate)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-written active-low segment table for expected values.
  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0": seg_of = 7'b1000000;
      "1": seg_of = 7'b1111001;
      "2": seg_of = 7'b0100100;
      "3": seg_of = 7'b0110000;
      "4": seg_of = 7'b0011001;
      "5": seg_of = 7'b0010010;
      "6": seg_of = 7'b0000010;
      "7": seg_of = 7'b1111000;
      "8": seg_of = 7'b0000000;
      "9": seg_of = 7'b0010000;
      "-": seg_of = 7'b0111111;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Leftmost character maps to the top 7 bits.
  function automatic logic [27:0] disp_of(input string s);
    logic [27:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[27 - 7*i -: 7] = seg_of(s[i]);
    return v;
  endfunction

  // Driver: one button press (mask of buttons) held for one rising edge.
  task automatic press(input logic [3:0] mask, input int times);
    for (int n = 0; n < times; n++) begin
      @(negedge clk);
      in = mask;
      @(negedge clk);
      in = 4'b0000;
      repeat (4) @(negedge clk);
    end
  endtask

  // Scan one full refresh period and capture each position's segments.
  task automatic read_disp(output logic [27:0] v, output logic onehot_ok);
    logic [6:0] seg [4];
    onehot_ok = 1'b1;
    for (int k = 0; k < 4; k++) seg[k] = 7'h7f;
    repeat (1 << RW) begin
      @(negedge clk);
      case (Anode_Activate)
        4'b1110: seg[0] = y;
        4'b1101: seg[1] = y;
        4'b1011: seg[2] = y;
        4'b0111: seg[3] = y;
        default: onehot_ok = 1'b0;
      endcase
    end
    v = {seg[3], seg[2], seg[1], seg[0]};
  endtask

  // Settle the registered result, then compare the whole display.
  task automatic check_disp(input string tag, input string exp_s);
    logic [27:0] v;
    logic        ok;
    repeat (3) @(negedge clk);
    read_disp(v, ok);
    check({tag, "_anode"}, {31'd0, ok}, 32'd1);
    check(tag, {4'd0, v}, {4'd0, disp_of(exp_s)});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rstn       = 1'b0;
    original   = 1'b0;
    in         = 4'b0000;
    operations = 4'b0000;

    repeat (3) @(negedge clk);
    check("reset_anode", {28'd0, Anode_Activate}, 32'h0000000e);
    check("reset_y", {25'd0, y}, 32'h00000040);
    rstn = 1'b1;

    check_disp("after_reset", "0000");

    press(4'b1111, 9);
    check_disp("ops_9999", "9999");
    operations = 4'b0010; check_disp("sub_99_99", "0000");
    operations = 4'b0001; check_disp("add_99_99", "0198");
    operations = 4'b1000; check_disp("div_99_99", "0001");
    operations = 4'b0100; check_disp("mul_99_99", "9801");

    press(4'b1000, 9);
    operations = 4'b0001; check_disp("add_99_98", "0197");

    press(4'b0001, 4);
    press(4'b0010, 3);
    operations = 4'b0100; check_disp("mul_32_98", "3136");
    operations = 4'b1000; check_disp("div_32_98", "0000");
    operations = 4'b0010;
`ifdef SUB_SIGN_EN
    check_disp("sub_32_98", "-066");
`else
    check_disp("sub_32_98", "0000");
`endif

    operations = 4'b0100;
    original   = 1'b1;
    check_disp("original_on", "3298");
    original   = 1'b0;
    check_disp("original_off", "3136");

    press(4'b0100, 1);
    press(4'b1000, 2);
    operations = 4'b1000; check_disp("div_by_zero", "----");
    operations = 4'b0011; check_disp("prio_add", "0032");
    operations = 4'b0110; check_disp("prio_sub", "0032");
    operations = 4'b1100; check_disp("prio_mul", "0000");
    operations = 4'b0000; check_disp("ops_3200", "3200");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
